// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage plus IF/ID pipeline register for the five-stage
// RISC-V core. Holds the PC, issues instruction-memory requests, and absorbs
// multi-cycle memory latency and decode stalls with a one-entry hold buffer.
// Redirects (branch / jalr) and bubbles arrive from the control unit.
//
// Parameters
//   XLEN      datapath width
//   RESET_PC  PC value after reset
//   NOP       bubble encoding loaded into IF/ID on squash
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   if_we          in   1 = IF/ID may advance, 0 = ID stalled
//   flush          in   squash the instruction entering ID this cycle
//   m4_1_cnt       in   next-PC select: 00 seq, 01/11 branch, 10 jalr
//   branch_target  in   PC-relative branch/jal target
//   jalr_target    in   jalr target (bit 0 cleared internally)
//   imem_req       out  fetch request valid (decoded from state)
//   imem_addr      out  fetch address = current PC
//   imem_rdata     in   instruction word, valid when imem_ready = 1
//   imem_ready     in   data for this cycle's imem_addr is present
//   id_inst        out  IF/ID instruction
//   id_pc          out  IF/ID PC
//   id_pc4         out  IF/ID PC+4
//   id_valid       out  IF/ID holds a real instruction
//   fetch_busy     out  request outstanding and not yet answered
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_we,
    input  logic            flush,
    input  logic [1:0]      m4_1_cnt,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [31:0]     id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc4,
    output logic            id_valid,
    output logic            fetch_busy
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [31:0]     r_hold_inst, w_hold_inst_nxt;
    logic [XLEN-1:0] r_hold_pc, w_hold_pc_nxt;
    logic [31:0]     r_id_inst, w_id_inst_nxt;
    logic [XLEN-1:0] r_id_pc, w_id_pc_nxt;
    logic [XLEN-1:0] r_id_pc4, w_id_pc4_nxt;
    logic            r_id_valid, w_id_valid_nxt;

    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_hold_pc4;

    // A flush with sequential select is only a bubble; any other select
    // moves the PC. Encoding 11 behaves like 01.
    assign w_redirect = flush & (m4_1_cnt != 2'b00);
    assign w_target   = (m4_1_cnt == 2'b10) ? {jalr_target[XLEN-1:1], 1'b0}
                                            : branch_target;
    assign w_pc_plus4 = r_pc + PC_INC;
    assign w_hold_pc4 = r_hold_pc + PC_INC;

    // Request is suppressed during reset so memory never sees a stale address
    // being requested while state is being cleared.
    assign imem_req   = (r_state == S_REQ) & ~rst;
    assign imem_addr  = r_pc;
    assign fetch_busy = imem_req & ~imem_ready;

    assign id_inst    = r_id_inst;
    assign id_pc      = r_id_pc;
    assign id_pc4     = r_id_pc4;
    assign id_valid   = r_id_valid;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_hold_inst_nxt = r_hold_inst;
        w_hold_pc_nxt   = r_hold_pc;
        w_id_inst_nxt   = r_id_inst;
        w_id_pc_nxt     = r_id_pc;
        w_id_pc4_nxt    = r_id_pc4;
        w_id_valid_nxt  = r_id_valid;

        // Flush beats stall: the IF/ID slot is squashed whatever if_we says,
        // while id_pc/id_pc4 keep their old values.
        if (flush) begin
            w_id_inst_nxt  = NOP;
            w_id_valid_nxt = 1'b0;
        end

        unique case (r_state)
            S_REQ: begin
                if (w_redirect) begin
                    // Current request is abandoned; memory never answers it.
                    w_pc_nxt = w_target;
                end else if (!flush) begin
                    if (imem_ready && if_we) begin
                        w_id_inst_nxt  = imem_rdata;
                        w_id_pc_nxt    = r_pc;
                        w_id_pc4_nxt   = w_pc_plus4;
                        w_id_valid_nxt = 1'b1;
                        w_pc_nxt       = w_pc_plus4;
                    end else if (imem_ready) begin
                        // ID is stalled but the word has arrived: park it so
                        // the request can retire and the PC can move on.
                        w_hold_inst_nxt = imem_rdata;
                        w_hold_pc_nxt   = r_pc;
                        w_pc_nxt        = w_pc_plus4;
                        w_state_nxt     = S_HOLD;
                    end else if (if_we) begin
                        w_id_inst_nxt  = NOP;
                        w_id_valid_nxt = 1'b0;
                    end
                end
            end

            S_HOLD: begin
                if (flush) begin
                    // Held word is dropped. A plain bubble leaves the PC
                    // pointing past it, since that word was the one squashed.
                    w_state_nxt = S_REQ;
                    if (w_redirect) begin
                        w_pc_nxt = w_target;
                    end
                end else if (if_we) begin
                    w_id_inst_nxt  = r_hold_inst;
                    w_id_pc_nxt    = r_hold_pc;
                    w_id_pc4_nxt   = w_hold_pc4;
                    w_id_valid_nxt = 1'b1;
                    w_state_nxt    = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_hold_inst <= NOP;
            r_hold_pc   <= '0;
            r_id_inst   <= NOP;
            r_id_pc     <= '0;
            r_id_pc4    <= '0;
            r_id_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_hold_inst <= w_hold_inst_nxt;
            r_hold_pc   <= w_hold_pc_nxt;
            r_id_inst   <= w_id_inst_nxt;
            r_id_pc     <= w_id_pc_nxt;
            r_id_pc4    <= w_id_pc4_nxt;
            r_id_valid  <= w_id_valid_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] KEY  = 32'hA5A5_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_we;
    logic            flush;
    logic [1:0]      m4_1_cnt;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jalr_target;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_ready;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc4;
    logic            id_valid;
    logic            fetch_busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Memory model: instruction word is a fixed function of its address.
    assign imem_rdata = imem_addr ^ KEY;

    fetch_stage #(.XLEN(XLEN), .RESET_PC(32'h0), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .if_we(if_we), .flush(flush), .m4_1_cnt(m4_1_cnt),
        .branch_target(branch_target), .jalr_target(jalr_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
        .id_valid(id_valid), .fetch_busy(fetch_busy)
    );

    // Inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; if_we = 1'b1; flush = 1'b0; m4_1_cnt = 2'b00;
        branch_target = '0; jalr_target = '0; imem_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %0h want 0", imem_req); end
        n_chk++; if (id_inst !== NOP) begin n_fail++; $display("FAIL rst_inst got %08h want %08h", id_inst, NOP); end
        n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0h want 0", id_valid); end
        n_chk++; if (id_pc !== 32'h0 || id_pc4 !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %08h/%08h want 0/0", id_pc, id_pc4); end
        n_chk++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0h want 0", fetch_busy); end
        rst = 1'b0;
        #1;
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req got req=%0h addr=%08h want 1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        step();
        n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== 32'hA5A5_0000) begin n_fail++; $display("FAIL seq0 got v=%0h pc=%08h inst=%08h want 1/00000000/a5a50000", id_valid, id_pc, id_inst); end
        n_chk++; if (id_pc4 !== 32'h4 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL seq0_next got pc4=%08h addr=%08h want 4/4", id_pc4, imem_addr); end
        step();
        n_chk++; if (id_pc !== 32'h4 || id_inst !== 32'hA5A5_0004 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL seq1 got pc=%08h inst=%08h addr=%08h want 4/a5a50004/8", id_pc, id_inst, imem_addr); end
    endtask

    task automatic test_stall_hold();
        if_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (imem_req !== 1'b0 || id_pc !== 32'h4 || id_inst !== 32'hA5A5_0004 || id_valid !== 1'b1) begin n_fail++; $display("FAIL hold%0d got req=%0h pc=%08h inst=%08h v=%0h want 0/4/a5a50004/1", i, imem_req, id_pc, id_inst, id_valid); end
        end
        if_we = 1'b1;
        step();
        n_chk++; if (id_pc !== 32'h8 || id_inst !== 32'hA5A5_0008 || id_valid !== 1'b1 || id_pc4 !== 32'hC) begin n_fail++; $display("FAIL hold_release got pc=%08h inst=%08h v=%0h pc4=%08h want 8/a5a50008/1/c", id_pc, id_inst, id_valid, id_pc4); end
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL hold_resume got req=%0h addr=%08h want 1/c", imem_req, imem_addr); end
        step();
        n_chk++; if (id_pc !== 32'hC || imem_addr !== 32'h10) begin n_fail++; $display("FAIL after_hold got pc=%08h addr=%08h want c/10", id_pc, imem_addr); end
    endtask

    task automatic test_branch();
        flush = 1'b1; m4_1_cnt = 2'b01; branch_target = 32'h40;
        step();
        flush = 1'b0; m4_1_cnt = 2'b00;
        n_chk++; if (id_valid !== 1'b0 || id_inst !== NOP || id_pc !== 32'hC) begin n_fail++; $display("FAIL br_bubble got v=%0h inst=%08h pc=%08h want 0/00000013/c", id_valid, id_inst, id_pc); end
        n_chk++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_addr got %08h want 00000040", imem_addr); end
        step();
        n_chk++; if (id_pc !== 32'h40 || id_inst !== 32'hA5A5_0040 || id_valid !== 1'b1) begin n_fail++; $display("FAIL br_target got pc=%08h inst=%08h v=%0h want 40/a5a50040/1", id_pc, id_inst, id_valid); end
    endtask

    task automatic test_flush_bubble_only();
        // PC now 0x44; a sequential-select flush squashes without moving PC.
        flush = 1'b1; m4_1_cnt = 2'b00; branch_target = 32'h999;
        step();
        flush = 1'b0;
        n_chk++; if (id_valid !== 1'b0 || id_inst !== NOP || imem_addr !== 32'h44) begin n_fail++; $display("FAIL bubble_only got v=%0h inst=%08h addr=%08h want 0/00000013/44", id_valid, id_inst, imem_addr); end
    endtask

    task automatic test_ready_low();
        // Select 11 must behave as branch.
        flush = 1'b1; m4_1_cnt = 2'b11; branch_target = 32'h14;
        step();
        flush = 1'b0; m4_1_cnt = 2'b00;
        n_chk++; if (imem_addr !== 32'h14) begin n_fail++; $display("FAIL sel11 got %08h want 00000014", imem_addr); end
        imem_ready = 1'b0;
        #1;
        n_chk++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL busy0 got %0h want 1", fetch_busy); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_chk++; if (id_valid !== 1'b0 || imem_addr !== 32'h14 || fetch_busy !== 1'b1) begin n_fail++; $display("FAIL wait%0d got v=%0h addr=%08h busy=%0h want 0/14/1", i, id_valid, imem_addr, fetch_busy); end
        end
        imem_ready = 1'b1;
        #1;
        n_chk++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL busy_clear got %0h want 0", fetch_busy); end
        step();
        n_chk++; if (id_pc !== 32'h14 || id_valid !== 1'b1 || imem_addr !== 32'h18) begin n_fail++; $display("FAIL wait_done got pc=%08h v=%0h addr=%08h want 14/1/18", id_pc, id_valid, imem_addr); end
    endtask

    task automatic test_jalr_in_hold();
        if_we = 1'b0;
        step();
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL jalr_pre_hold got req=%0h want 0", imem_req); end
        flush = 1'b1; m4_1_cnt = 2'b10; jalr_target = 32'h101;
        step();
        flush = 1'b0; m4_1_cnt = 2'b00; if_we = 1'b1;
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || id_valid !== 1'b0 || id_inst !== NOP) begin n_fail++; $display("FAIL jalr_hold got req=%0h addr=%08h v=%0h inst=%08h want 1/100/0/00000013", imem_req, imem_addr, id_valid, id_inst); end
        step();
        n_chk++; if (id_pc !== 32'h100 || id_inst !== 32'hA5A5_0100 || id_valid !== 1'b1) begin n_fail++; $display("FAIL jalr_target got pc=%08h inst=%08h v=%0h want 100/a5a50100/1", id_pc, id_inst, id_valid); end
    endtask

    task automatic test_wrap();
        flush = 1'b1; m4_1_cnt = 2'b01; branch_target = 32'hFFFF_FFFC;
        step();
        flush = 1'b0; m4_1_cnt = 2'b00;
        step();
        n_chk++; if (id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap got pc=%08h pc4=%08h addr=%08h want fffffffc/0/0", id_pc, id_pc4, imem_addr); end
    endtask

    task automatic test_reset_mid();
        flush = 1'b1; m4_1_cnt = 2'b01; branch_target = 32'h20;
        step();
        flush = 1'b0; m4_1_cnt = 2'b00;
        step();
        if_we = 1'b0;
        step();
        n_chk++; if (imem_req !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h20) begin n_fail++; $display("FAIL pre_rst_hold got req=%0h v=%0h pc=%08h want 0/1/20", imem_req, id_valid, id_pc); end
        #2 rst = 1'b1;
        #1;
        n_chk++; if (id_valid !== 1'b0 || imem_req !== 1'b0 || id_inst !== NOP || id_pc !== 32'h0) begin n_fail++; $display("FAIL async_rst got v=%0h req=%0h inst=%08h pc=%08h want 0/0/00000013/0", id_valid, imem_req, id_inst, id_pc); end
        @(negedge clk);
        rst = 1'b0; if_we = 1'b1;
        #1;
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL post_rst got req=%0h addr=%08h want 1/0", imem_req, imem_addr); end
        step();
        n_chk++; if (id_pc !== 32'h0 || id_valid !== 1'b1 || id_inst !== 32'hA5A5_0000) begin n_fail++; $display("FAIL post_rst_fetch got pc=%08h v=%0h inst=%08h want 0/1/a5a50000", id_pc, id_valid, id_inst); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_branch();
        test_flush_bubble_only();
        test_ready_low();
        test_jalr_in_hold();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
